// File: rtl/irq_prio_pkg.sv
// ============================================================================
//  Module      : irq_prio_pkg
//  Description : Shared types, default group map and priority-encode helper
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package irq_prio_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Nibble s = mask group of source s (nibble 0 unused: source 0 is an NMI).
    localparam logic [127:0] c_group_map_default =
        128'h9999_8888_7777_6666_5555_4444_4443_2100;

    // Lowest set index among the first n bits of v; n when none is set.
    function automatic logic [6:0] lowest_set(input logic [63:0] v, input int n);
        logic [6:0] r;
        r = 7'(n);
        for (int i = 63; i >= 0; i--) begin
            if (i < n && v[i]) r = 7'(i);
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_prio_if.sv
// ============================================================================
//  Module      : irq_prio_if
//  Description : Request / software / CPU-side bundle of the interrupt block
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface irq_prio_if #(
    parameter int NIRQ  = 32,
    parameter int NMASK = 10,
    parameter int DEPTH = 8
);
    logic [NIRQ-1:0]              irq_;
    logic [NIRQ-1:0]              w;
    logic                         w_rm;
    logic                         w_set;
    logic                         w_clr;
    logic                         ack;
    logic                         eoi;
    logic [NMASK-1:0]             rm;
    logic [NIRQ-1:0]              rz;
    logic [NIRQ-1:0]              rp;
    logic                         irq;
    logic [$clog2(NIRQ)-1:0]      vec;
    logic                         vec_v;
    logic [$clog2(DEPTH+1)-1:0]   lvl;
    logic                         ovf;
    logic                         unf;

    modport master (
        output irq_, w, w_rm, w_set, w_clr, ack, eoi,
        input  rm, rz, rp, irq, vec, vec_v, lvl, ovf, unf
    );

    modport slave (
        input  irq_, w, w_rm, w_set, w_clr, ack, eoi,
        output rm, rz, rp, irq, vec, vec_v, lvl, ovf, unf
    );
endinterface

`default_nettype wire

// File: rtl/irq_stack.sv
// ============================================================================
//  Module      : irq_stack
//  Description : Saturating LIFO holding saved mask registers across nesting
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module irq_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  wire logic                         clk,
    input  wire logic                         rst_n,
    input  wire logic                         i_push,
    input  wire logic                         i_pop,
    input  wire logic [WIDTH-1:0]             i_din,
    output logic      [WIDTH-1:0]             o_dout,
    output logic                              o_full,
    output logic                              o_empty,
    output logic      [$clog2(DEPTH+1)-1:0]   o_lvl
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    assign w_wr_idx = AW'(r_ptr);
    assign w_rd_idx = AW'(r_ptr - PW'(1));
    assign o_full   = (r_ptr == PW'(DEPTH));
    assign o_empty  = (r_ptr == '0);
    assign o_dout   = r_mem[w_rd_idx];
    assign o_lvl    = r_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_din;
            r_ptr           <= r_ptr + PW'(1);
        end else if (i_pop && !o_empty) begin
            r_ptr <= r_ptr - PW'(1);
        end
    end
endmodule

`default_nettype wire

// File: rtl/irq_prio.sv
// ============================================================================
//  Module      : irq_prio
//  Description : Nested priority interrupt controller with grouped masking
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module irq_prio
    import irq_prio_pkg::*;
#(
    parameter int                 NIRQ      = 32,
    parameter int                 NMASK     = 10,
    parameter logic [NIRQ*4-1:0]  GROUP_MAP = c_group_map_default,
    parameter logic [NIRQ-1:0]    LEVEL     = '0,
    parameter int                 DEPTH     = 8
) (
    input wire logic  __clk,
    input wire logic  clm_,
    irq_prio_if.slave bus
);
    localparam int VW = $clog2(NIRQ);
    localparam int LW = $clog2(DEPTH + 1);

    logic [NIRQ-1:0]  r_s1, r_s2, r_s3;
    logic [NIRQ-1:0]  r_rz, r_rp;
    logic [NMASK-1:0] r_rm;
    state_t           r_state;
    logic             r_irq, r_ovf, r_unf;
    logic [VW-1:0]    r_vec;

    logic [NIRQ-1:0]  w_hw, w_en, w_pend, w_rz_nxt;
    logic [3:0]       w_grp [NIRQ];
    logic [15:0]      w_rm16;
    logic [6:0]       w_top, w_svc;
    logic [VW-1:0]    w_top_i, w_svc_i;
    logic [3:0]       w_gs;
    logic [NMASK-1:0] w_keep, w_stk_top;
    logic             w_qual, w_grant, w_eoi, w_full, w_empty;
    logic [LW-1:0]    w_lvl;

    assign w_rm16 = 16'(r_rm);

    for (genvar s = 0; s < NIRQ; s++) begin : g_src
        assign w_grp[s] = GROUP_MAP[4*s +: 4];
        if (s == 0) begin : g_nmi
            assign w_en[s] = 1'b1;
        end else begin : g_mask
            assign w_en[s] = w_rm16[w_grp[s]];
        end
    end

    for (genvar g = 0; g < NMASK; g++) begin : g_keep
        assign w_keep[g] = (4'(g) < w_gs);
    end

    // Edge sources fire on a synchronised fall, level sources while low.
    assign w_hw    = (r_s3 & ~r_s2 & ~LEVEL) | (~r_s2 & LEVEL);
    assign w_pend  = r_rz & w_en;
    assign w_top   = lowest_set(64'(w_pend), NIRQ);
    assign w_svc   = lowest_set(64'(r_rp), NIRQ);
    assign w_top_i = VW'(w_top);
    assign w_svc_i = VW'(w_svc);
    assign w_qual  = (w_top < w_svc);
    assign w_gs    = (w_top_i == '0) ? 4'd0 : w_grp[w_top_i];
    assign w_grant = (r_state == IDLE) && bus.ack && !bus.eoi && w_qual && !w_full;
    assign w_eoi   = (r_state == IDLE) && bus.eoi && !w_empty;

    // Applied lowest precedence first so later terms override earlier ones.
    always_comb begin
        w_rz_nxt = r_rz;
        if (w_grant && !LEVEL[w_top_i]) w_rz_nxt[w_top_i] = 1'b0;
        if (bus.w_clr) w_rz_nxt = w_rz_nxt & ~bus.w;
        if (bus.w_set) w_rz_nxt = w_rz_nxt | bus.w;
        w_rz_nxt = w_rz_nxt | w_hw;
    end

    always_ff @(posedge __clk) begin
        if (!clm_) begin
            r_s1    <= '1;
            r_s2    <= '1;
            r_s3    <= '1;
            r_rz    <= '0;
            r_rp    <= '0;
            r_rm    <= '1;
            r_state <= IDLE;
            r_irq   <= 1'b0;
            r_vec   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_s1  <= bus.irq_;
            r_s2  <= r_s1;
            r_s3  <= r_s2;
            r_rz  <= w_rz_nxt;
            r_irq <= w_qual;
            if (bus.ack && !w_grant) r_ovf <= 1'b1;
            if (bus.eoi && !w_eoi)   r_unf <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state        <= GRANT;
                        r_vec          <= w_top_i;
                        r_rp[w_top_i]  <= 1'b1;
                    end else if (w_eoi) begin
                        r_rp[w_svc_i]  <= 1'b0;
                    end
                end
                GRANT:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (bus.w_rm)     r_rm <= bus.w[NMASK-1:0];
            else if (w_grant) r_rm <= r_rm & w_keep;
            else if (w_eoi)   r_rm <= w_stk_top;
        end
    end

    irq_stack #(
        .WIDTH (NMASK),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (__clk),
        .rst_n   (clm_),
        .i_push  (w_grant),
        .i_pop   (w_eoi),
        .i_din   (r_rm),
        .o_dout  (w_stk_top),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_lvl   (w_lvl)
    );

    assign bus.rm    = r_rm;
    assign bus.rz    = r_rz;
    assign bus.rp    = r_rp;
    assign bus.irq   = r_irq;
    assign bus.vec   = r_vec;
    assign bus.vec_v = (r_state == GRANT);
    assign bus.lvl   = w_lvl;
    assign bus.ovf   = r_ovf;
    assign bus.unf   = r_unf;
endmodule

`default_nettype wire

// File: tb/tb_irq_prio.sv
// ============================================================================
//  Module      : tb_irq_prio
//  Description : Directed self-checking bench for irq_prio (DEPTH = 2)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_irq_prio;
    import irq_prio_pkg::*;

    localparam int NIRQ  = 32;
    localparam int NMASK = 10;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic clm_;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_vec_q [$];

    irq_prio_if #(.NIRQ(NIRQ), .NMASK(NMASK), .DEPTH(DEPTH)) bus ();

    irq_prio #(
        .NIRQ      (NIRQ),
        .NMASK     (NMASK),
        .GROUP_MAP (c_group_map_default),
        .LEVEL     (32'h4000_0000),
        .DEPTH     (DEPTH)
    ) dut (
        .__clk (clk),
        .clm_  (clm_),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int s);
        bus.irq_[s] = 1'b0;
        tick();
        bus.irq_[s] = 1'b1;
    endtask

    task automatic ack_grant(input int s);
        exp_vec_q.push_back(s);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("vec_v", 64'(bus.vec_v), 64'd1);
        chk("vec", 64'(bus.vec), 64'(exp_vec_q.pop_front()));
    endtask

    task automatic do_eoi();
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
    endtask

    task automatic check_reset();
        chk("rst_rz", 64'(bus.rz), 64'd0);
        chk("rst_rp", 64'(bus.rp), 64'd0);
        chk("rst_rm", 64'(bus.rm), 64'h3FF);
        chk("rst_lvl", 64'(bus.lvl), 64'd0);
        chk("rst_irq", 64'(bus.irq), 64'd0);
        chk("rst_vec", 64'(bus.vec), 64'd0);
        chk("rst_vec_v", 64'(bus.vec_v), 64'd0);
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
        chk("rst_unf", 64'(bus.unf), 64'd0);
    endtask

    initial begin
        bus.irq_  = '1;
        bus.w     = '0;
        bus.w_rm  = 1'b0;
        bus.w_set = 1'b0;
        bus.w_clr = 1'b0;
        bus.ack   = 1'b0;
        bus.eoi   = 1'b0;
        clm_      = 1'b0;
        tick(2);
        check_reset();
        clm_ = 1'b1;

        // Single edge request: four-cycle latency, then grant of source 5
        pulse(5);
        chk("lat_e1", 64'(bus.irq), 64'd0);
        tick();
        chk("lat_e2", 64'(bus.irq), 64'd0);
        tick();
        chk("lat_e3", 64'(bus.irq), 64'd0);
        chk("rz5_set", 64'(bus.rz), 64'h20);
        tick();
        chk("lat_e4", 64'(bus.irq), 64'd1);
        ack_grant(5);
        chk("g5_rz", 64'(bus.rz), 64'd0);
        chk("g5_rp", 64'(bus.rp), 64'h20);
        chk("g5_rm", 64'(bus.rm), 64'h00F);
        chk("g5_lvl", 64'(bus.lvl), 64'd1);
        tick();
        chk("g5_vec_v_drop", 64'(bus.vec_v), 64'd0);
        do_eoi();
        chk("e5_rp", 64'(bus.rp), 64'd0);
        chk("e5_rm", 64'(bus.rm), 64'h3FF);
        chk("e5_lvl", 64'(bus.lvl), 64'd0);

        // Nesting: serve 10, then 3 preempts while 20 stays masked
        pulse(10);
        tick(3);
        chk("r10_irq", 64'(bus.irq), 64'd1);
        ack_grant(10);
        chk("g10_rm", 64'(bus.rm), 64'h00F);
        pulse(3);
        pulse(20);
        tick(2);
        chk("r3_irq", 64'(bus.irq), 64'd1);
        chk("r3_20_rz", 64'(bus.rz), 64'h0010_0008);
        ack_grant(3);
        chk("g3_lvl", 64'(bus.lvl), 64'd2);
        chk("g3_rp", 64'(bus.rp), 64'h408);
        chk("g3_rm", 64'(bus.rm), 64'h003);
        tick();
        chk("g3_irq_low", 64'(bus.irq), 64'd0);
        do_eoi();
        chk("e3_rm", 64'(bus.rm), 64'h00F);
        chk("e3_lvl", 64'(bus.lvl), 64'd1);
        do_eoi();
        chk("e10_rp", 64'(bus.rp), 64'd0);
        chk("e10_rm", 64'(bus.rm), 64'h3FF);
        chk("e10_irq", 64'(bus.irq), 64'd0);
        tick();
        chk("r20_irq", 64'(bus.irq), 64'd1);
        ack_grant(20);
        tick();
        do_eoi();
        chk("e20_lvl", 64'(bus.lvl), 64'd0);
        chk("e20_rm", 64'(bus.rm), 64'h3FF);

        // Group 4 masked: 5..11 stay silent, NMI source 0 still gets through
        bus.w    = 32'h3EF;
        bus.w_rm = 1'b1;
        tick();
        bus.w_rm = 1'b0;
        bus.w    = '0;
        chk("wrm_rm", 64'(bus.rm), 64'h3EF);
        bus.irq_[11:5] = '0;
        tick();
        bus.irq_[11:5] = '1;
        tick(4);
        chk("mask_irq", 64'(bus.irq), 64'd0);
        chk("mask_rz", 64'(bus.rz), 64'hFE0);
        pulse(0);
        tick(3);
        chk("nmi_irq", 64'(bus.irq), 64'd1);
        ack_grant(0);
        chk("nmi_rm", 64'(bus.rm), 64'h000);
        tick();
        do_eoi();
        chk("nmi_eoi_rm", 64'(bus.rm), 64'h3EF);
        bus.w     = '1;
        bus.w_clr = 1'b1;
        bus.w_rm  = 1'b1;
        tick();
        bus.w_clr = 1'b0;
        bus.w_rm  = 1'b0;
        bus.w     = '0;
        chk("clr_rz", 64'(bus.rz), 64'd0);
        chk("clr_rm", 64'(bus.rm), 64'h3FF);

        // Stack full: third nested ack dropped, then underflow
        pulse(12);
        tick(3);
        ack_grant(12);
        chk("g12_rm", 64'(bus.rm), 64'h01F);
        tick();
        pulse(6);
        tick(3);
        chk("r6_irq", 64'(bus.irq), 64'd1);
        ack_grant(6);
        chk("g6_rm", 64'(bus.rm), 64'h00F);
        tick();
        pulse(2);
        tick(3);
        chk("r2_irq", 64'(bus.irq), 64'd1);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("ovf_vec_v", 64'(bus.vec_v), 64'd0);
        chk("ovf_flag", 64'(bus.ovf), 64'd1);
        chk("ovf_lvl", 64'(bus.lvl), 64'd2);
        chk("ovf_rp", 64'(bus.rp), 64'h1040);
        chk("ovf_rz", 64'(bus.rz), 64'h4);
        do_eoi();
        chk("pop1_rm", 64'(bus.rm), 64'h01F);
        chk("pop1_lvl", 64'(bus.lvl), 64'd1);
        do_eoi();
        chk("pop2_rm", 64'(bus.rm), 64'h3FF);
        chk("pop2_lvl", 64'(bus.lvl), 64'd0);
        chk("pop2_unf", 64'(bus.unf), 64'd0);
        do_eoi();
        chk("unf_flag", 64'(bus.unf), 64'd1);
        chk("unf_lvl", 64'(bus.lvl), 64'd0);

        clm_ = 1'b0;
        tick();
        clm_ = 1'b1;
        chk("sticky_ovf_clr", 64'(bus.ovf), 64'd0);
        chk("sticky_unf_clr", 64'(bus.unf), 64'd0);

        // Same-cycle ack + eoi, then set-vs-clear on one RZ bit
        pulse(7);
        tick(3);
        ack_grant(7);
        tick();
        pulse(1);
        tick(3);
        chk("r1_irq", 64'(bus.irq), 64'd1);
        bus.ack = 1'b1;
        bus.eoi = 1'b1;
        tick();
        bus.ack = 1'b0;
        bus.eoi = 1'b0;
        chk("ae_vec_v", 64'(bus.vec_v), 64'd0);
        chk("ae_ovf", 64'(bus.ovf), 64'd1);
        chk("ae_unf", 64'(bus.unf), 64'd0);
        chk("ae_rp", 64'(bus.rp), 64'd0);
        chk("ae_lvl", 64'(bus.lvl), 64'd0);
        chk("ae_rm", 64'(bus.rm), 64'h3FF);
        chk("ae_rz", 64'(bus.rz), 64'h2);
        bus.w     = 32'h2000;
        bus.w_set = 1'b1;
        bus.w_clr = 1'b1;
        tick();
        bus.w_set = 1'b0;
        chk("setclr_rz", 64'(bus.rz), 64'h2002);
        tick();
        bus.w_clr = 1'b0;
        bus.w     = '0;
        chk("clr13_rz", 64'(bus.rz), 64'h2);

        // Reset in GRANT overrides everything; level source re-requests
        ack_grant(1);
        clm_         = 1'b0;
        bus.irq_[30] = 1'b0;
        bus.eoi      = 1'b1;
        bus.w        = '1;
        bus.w_set    = 1'b1;
        tick();
        check_reset();
        bus.eoi   = 1'b0;
        bus.w_set = 1'b0;
        bus.w     = '0;
        clm_      = 1'b1;
        tick(2);
        chk("lvl30_e2", 64'(bus.rz), 64'd0);
        tick();
        chk("lvl30_e3", 64'(bus.rz), 64'h4000_0000);
        bus.irq_[30] = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/irq_prio.md
IRQ_PRIO -- requirements
Module: irq_prio

Interface
REQ-001 SHALL have parameter NIRQ, default 32; number of interrupt sources, range 2..64.
REQ-002 SHALL have parameter NMASK, default 10; number of mask groups, range 1..16.
REQ-003 SHALL have parameter GROUP_MAP, default 32x4-bit packed map; field s is the mask group of source s, and field 0 is ignored because source 0 is non-maskable.
REQ-004 SHALL have parameter LEVEL, default all zeros, NIRQ bits; 1 = level-sensitive source, 0 = edge (falling) source.
REQ-005 SHALL have parameter DEPTH, default 8; nesting stack depth, range 1..16.
REQ-006 SHALL have port __clk, input, 1 bit; sole clock, rising edge.
REQ-007 SHALL have port clm_, input, 1 bit; reset, synchronous and active-low.
REQ-008 SHALL have port irq_, input, NIRQ bits; asynchronous requests, active-low.
REQ-009 SHALL have port w, input, NIRQ bits; software write data.
REQ-010 SHALL have port w_rm, input, 1 bit; load RM from w[0:NMASK-1].
REQ-011 SHALL have port w_set, input, 1 bit; OR w into RZ.
REQ-012 SHALL have port w_clr, input, 1 bit; clear the RZ bits that are set in w.
REQ-013 SHALL have port ack, input, 1 bit; CPU interrupt acknowledge, one-cycle pulse.
REQ-014 SHALL have port eoi, input, 1 bit; end-of-interrupt pulse.
REQ-015 SHALL have port rm, output, NMASK bits; mask register.
REQ-016 SHALL have port rz, output, NIRQ bits; request register.
REQ-017 SHALL have port rp, output, NIRQ bits; in-service register.
REQ-018 SHALL have port irq, output, 1 bit; interrupt request to the CPU.
REQ-019 SHALL have port vec, output, clog2(NIRQ) bits; number of the granted source.
REQ-020 SHALL have port vec_v, output, 1 bit; vec valid, one-cycle pulse.
REQ-021 SHALL have port lvl, output, clog2(DEPTH+1) bits; current nesting depth.
REQ-022 SHALL have port ovf, output, 1 bit; sticky stack overflow / dropped ack.
REQ-023 SHALL have port unf, output, 1 bit; sticky eoi with empty stack.

Function
REQ-024 Each irq_ bit SHALL pass through a 2-FF synchroniser; an edge source sets RZ on a synchronised 1->0 transition, and a level source sets RZ every cycle it is low.
REQ-025 Lower source index SHALL mean higher priority; source 0 is always enabled.
REQ-026 Source s>0 SHALL be enabled when rm[GROUP_MAP[s]]=1.
REQ-027 The pending vector SHALL be P = RZ & enabled; the top request is the lowest set index of P.
REQ-028 The in-service level SHALL be the lowest set index of RP, or NIRQ when RP=0.
REQ-029 irq SHALL be registered and assert the cycle after P has a set bit with index below the in-service level; it drops in the cycle after that condition clears.
REQ-030 Input-to-irq latency SHALL be 4 cycles: 2 synchroniser cycles, 1 RZ cycle, 1 irq cycle.
REQ-031 The FSM SHALL have two states, IDLE and GRANT.
REQ-032 In IDLE with ack=1 and a top request s qualifying per REQ-029, the block SHALL, at the next edge: enter GRANT; latch vec=s; push RM; set RP[s]; clear RZ[s] (edge sources only); clear every rm[g] with g>=GROUP_MAP[s] (all bits when s=0); increment lvl.
REQ-033 The FSM SHALL leave GRANT for IDLE unconditionally after one cycle, and vec_v SHALL equal (state==GRANT).
REQ-034 ack with no qualifying request, ack outside IDLE, or ack with lvl=DEPTH SHALL be ignored and set ovf; an ignored ack SHALL change no other state.
REQ-035 eoi in IDLE with lvl>0 SHALL clear the lowest set RP bit, pop RM, and decrement lvl; eoi with lvl=0 SHALL set unf and change nothing else.
REQ-036 eoi and ack in the same IDLE cycle SHALL perform the eoi, drop the ack, and set ovf; eoi in GRANT SHALL be ignored and set unf.
REQ-037 The same-cycle RZ precedence order, highest first, SHALL be: hardware set, then w_set, then w_clr, then ack-clear.
REQ-038 w_rm SHALL win over a same-cycle mask change from grant or eoi.
REQ-039 The RM stack SHALL be a LIFO of DEPTH entries with no wrap-around, and its pointer SHALL saturate.
REQ-040 ovf and unf SHALL be cleared only by reset.

Reset
REQ-041 With clm_=0 at a clock edge, the block SHALL set RZ=0, RP=0, RM=all ones, lvl=0, stack pointer=0, state=IDLE, irq=0, vec=0, vec_v=0, ovf=0, unf=0, and synchroniser flops=1.
REQ-042 Reset SHALL override every same-cycle input, including a reset asserted during GRANT.
REQ-043 Level sources held low SHALL re-request within 3 cycles after release of clm_.

Structure
REQ-044 A shared package SHALL hold the state enum (IDLE, GRANT), the default GROUP_MAP constant, and the function that computes the lowest set index with NIRQ as the empty result.
REQ-045 The block SHALL contain one sub-module, irq_stack, a parametrised LIFO (width NMASK, depth DEPTH) providing push, pop, full, empty and level.

Verification
REQ-046 The bench SHALL drive irq_[5] low for 1 cycle with rm=all ones and check irq=1 exactly 4 cycles later; then ack, and check vec_v=1 with vec=5 next cycle, RZ[5]=0, RP[5]=1, and rm bits >= GROUP_MAP[5] cleared.
REQ-047 The bench SHALL, while serving 10, raise 3 and then 20, and check that only 3 raises irq; after ack check vec=3 and lvl=2; after two eois check RP=0, rm restored to all ones, then irq for 20.
REQ-048 The bench SHALL clear rm group 4 and raise sources 5..11, and check irq stays 0; raising source 0 SHALL still give irq=1 and vec=0.
REQ-049 With DEPTH=2, the bench SHALL ack three nested requests and check the third is dropped, ovf=1, and lvl=2; a further eoi x3 SHALL give unf=1 and lvl=0.
REQ-050 The bench SHALL issue ack and eoi in the same cycle and check that only the eoi is applied and ovf=1; w_set and w_clr on the same bit SHALL leave the bit set.
REQ-051 The bench SHALL assert clm_=0 during GRANT and check vec_v=0 and all reset values from REQ-041 on the next cycle.
